pump_sched_multi: RTL and testbench

Multi-channel periodic pump scheduler: successor to the single-channel pump timer, driving `NUM_PUMPS` independent pump outputs. Each channel has its own period, on-time and repeat count, with per-channel start/stop/force controls. A global limit caps how many pumps may run at once. Sits between the command/register layer and the pump driver pins; shares one seconds-tick prescaler across all channels.

---
 rtl/pump_pkg.sv | 14 +
 rtl/sec_tick_gen.sv | 27 ++
 rtl/pump_sched_multi.sv | 180 ++++++++++++++++++
 tb/tb_pump_sched_multi.sv | 316 +++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/pump_pkg.sv
// Shared types and width defaults for the multi-channel pump scheduler.
package pump_pkg;

   typedef enum logic [1:0] {
      StIdle = 2'd0,
      StWait = 2'd1,
      StPend = 2'd2,
      StOn   = 2'd3
   } pump_state_e;

   localparam int unsigned TIME_W_DEF = 16;
   localparam int unsigned REP_W_DEF  = 8;

endpackage

// File: rtl/sec_tick_gen.sv
// Free-running prescaler producing a one-cycle tick every TICK_DIV clocks.
module sec_tick_gen #(
   parameter int unsigned TICK_DIV = 1_000_000
) (
   input  logic clk,
   input  logic rst,
   output logic tick
);

   localparam int unsigned CW = $clog2(TICK_DIV);
   localparam logic [CW-1:0] LAST = CW'(TICK_DIV - 1);

   logic [CW-1:0] cnt_q;

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         cnt_q <= '0;
      end else if (cnt_q == LAST) begin
         cnt_q <= '0;
      end else begin
         cnt_q <= cnt_q + 1'b1;
      end
   end

   assign tick = (cnt_q == LAST);

endmodule

// File: rtl/pump_sched_multi.sv
// Multi-channel periodic pump scheduler with a shared seconds tick and a
// fixed-priority arbiter capping the number of simultaneously running pumps.
module pump_sched_multi
   import pump_pkg::*;
#(
   parameter int unsigned NUM_PUMPS  = 4,
   parameter int unsigned TIME_W     = TIME_W_DEF,
   parameter int unsigned REP_W      = REP_W_DEF,
   parameter int unsigned TICK_DIV   = 1_000_000,
   parameter int unsigned MAX_ACTIVE = 2
) (
   input  logic                              clk,
   input  logic                              rst,
   input  logic [NUM_PUMPS-1:0]              start,
   input  logic [NUM_PUMPS-1:0]              stop,
   input  logic [NUM_PUMPS-1:0]              force_req,
   input  logic [NUM_PUMPS*TIME_W-1:0]       period_s,
   input  logic [NUM_PUMPS*TIME_W-1:0]       on_s,
   input  logic [NUM_PUMPS*REP_W-1:0]        repeat_n,
   output logic [NUM_PUMPS-1:0]              pump_out,
   output logic [NUM_PUMPS-1:0]              busy,
   output logic [NUM_PUMPS-1:0]              done,
   output logic [$clog2(NUM_PUMPS+1)-1:0]    active_cnt
);

   localparam int unsigned CNT_W = $clog2(NUM_PUMPS + 1);
   localparam logic [CNT_W:0] MAX_L = MAX_ACTIVE[CNT_W:0];

   logic                 tick;
   logic [NUM_PUMPS-1:0] start_prev_q, force_prev_q;
   logic [NUM_PUMPS-1:0] req, grant;
   logic [CNT_W:0]       used;

   sec_tick_gen #(
      .TICK_DIV (TICK_DIV)
   ) u_tick (
      .clk  (clk),
      .rst  (rst),
      .tick (tick)
   );

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         start_prev_q <= '0;
         force_prev_q <= '0;
      end else begin
         start_prev_q <= start;
         force_prev_q <= force_req;
      end
   end

   always_comb begin
      active_cnt = '0;
      for (int i = 0; i < NUM_PUMPS; i++) begin
         active_cnt = active_cnt + CNT_W'(pump_out[i]);
      end
   end

   // Slots freed by a channel leaving ON only show up in active_cnt next cycle.
   always_comb begin
      used  = {1'b0, active_cnt};
      grant = '0;
      for (int i = 0; i < NUM_PUMPS; i++) begin
         if (req[i] && (used < MAX_L)) begin
            grant[i] = 1'b1;
            used     = used + 1'b1;
         end
      end
   end

   for (genvar i = 0; i < NUM_PUMPS; i++) begin : g_ch
      pump_state_e       state_q;
      logic [TIME_W-1:0] cnt_q, period_q, on_q;
      logic [TIME_W-1:0] period_in, on_in, cnt_inc;
      logic [REP_W-1:0]  rem_q;
      logic              periodic_q, pump_q, busy_q, done_q;
      logic              start_edge, force_edge;

      assign period_in  = (period_s[i*TIME_W +: TIME_W] == '0) ? TIME_W'(1)
                                                              : period_s[i*TIME_W +: TIME_W];
      assign on_in      = (on_s[i*TIME_W +: TIME_W] == '0) ? TIME_W'(1)
                                                          : on_s[i*TIME_W +: TIME_W];
      assign cnt_inc    = cnt_q + 1'b1;
      assign start_edge = start[i] & ~start_prev_q[i];
      assign force_edge = force_req[i] & ~force_prev_q[i];
      // Channels being stopped or restarted do not compete for a slot.
      assign req[i]     = (state_q == StPend) & ~stop[i] & ~start_edge;

      always_ff @(posedge clk or posedge rst) begin
         if (rst) begin
            state_q    <= StIdle;
            cnt_q      <= '0;
            period_q   <= '0;
            on_q       <= '0;
            rem_q      <= '0;
            periodic_q <= 1'b0;
            pump_q     <= 1'b0;
            busy_q     <= 1'b0;
            done_q     <= 1'b0;
         end else begin
            done_q <= 1'b0;
            if (stop[i]) begin
               state_q    <= StIdle;
               cnt_q      <= '0;
               rem_q      <= '0;
               periodic_q <= 1'b0;
               pump_q     <= 1'b0;
               busy_q     <= 1'b0;
            end else if (start_edge) begin
               state_q    <= StWait;
               cnt_q      <= '0;
               period_q   <= period_in;
               on_q       <= on_in;
               rem_q      <= repeat_n[i*REP_W +: REP_W];
               periodic_q <= 1'b1;
               pump_q     <= 1'b0;
               busy_q     <= 1'b1;
            end else if (force_edge && (state_q == StIdle)) begin
               state_q    <= StPend;
               cnt_q      <= '0;
               period_q   <= period_in;
               on_q       <= on_in;
               periodic_q <= 1'b0;
               busy_q     <= 1'b1;
            end else if (force_edge && (state_q == StWait)) begin
               state_q <= StPend;
               cnt_q   <= '0;
            end else begin
               case (state_q)
                  StWait: begin
                     if (tick) begin
                        if (cnt_inc == period_q) begin
                           state_q <= StPend;
                           cnt_q   <= '0;
                        end else begin
                           cnt_q <= cnt_inc;
                        end
                     end
                  end
                  StPend: begin
                     if (grant[i]) begin
                        state_q <= StOn;
                        cnt_q   <= '0;
                        pump_q  <= 1'b1;
                     end
                  end
                  StOn: begin
                     if (tick) begin
                        if (cnt_inc == on_q) begin
                           pump_q <= 1'b0;
                           cnt_q  <= '0;
                           if (!periodic_q) begin
                              state_q <= StIdle;
                              busy_q  <= 1'b0;
                           end else if (rem_q == REP_W'(1)) begin
                              state_q <= StIdle;
                              busy_q  <= 1'b0;
                              done_q  <= 1'b1;
                              rem_q   <= '0;
                           end else begin
                              state_q <= StWait;
                              if (rem_q != '0) rem_q <= rem_q - 1'b1;
                           end
                        end else begin
                           cnt_q <= cnt_inc;
                        end
                     end
                  end
                  default: ;
               endcase
            end
         end
      end

      assign pump_out[i] = pump_q;
      assign busy[i]     = busy_q;
      assign done[i]     = done_q;
   end

endmodule

// File: tb/tb_pump_sched_multi.sv
// Self-checking bench: countdown-style reference model compared every cycle,
// plus directed scenarios with hand-derived pulse widths and event timing.
module tb_pump_sched_multi;

   localparam int NP = 4;
   localparam int TW = 16;
   localparam int RW = 8;
   localparam int TD = 4;
   localparam int MA = 2;

   logic              clk, rst;
   logic [NP-1:0]     start, stop, force_req;
   logic [NP*TW-1:0]  period_s, on_s;
   logic [NP*RW-1:0]  repeat_n;
   logic [NP-1:0]     pump_out, busy, done;
   logic [2:0]        active_cnt;

   int compared   = 0;
   int mismatched = 0;

   pump_sched_multi #(
      .NUM_PUMPS  (NP),
      .TIME_W     (TW),
      .REP_W      (RW),
      .TICK_DIV   (TD),
      .MAX_ACTIVE (MA)
   ) dut (
      .clk        (clk),
      .rst        (rst),
      .start      (start),
      .stop       (stop),
      .force_req  (force_req),
      .period_s   (period_s),
      .on_s       (on_s),
      .repeat_n   (repeat_n),
      .pump_out   (pump_out),
      .busy       (busy),
      .done       (done),
      .active_cnt (active_cnt)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   task automatic chk(input string nm, input int act, input int exp);
      compared++;
      if (act != exp) begin
         mismatched++;
         $display("FAIL %s: got %0d expected %0d (t=%0t)", nm, act, exp, $time);
      end
   endtask

   function automatic int clamp1(input int v);
      return (v == 0) ? 1 : v;
   endfunction

   // Reference model: seconds counted down, arbitration by slot budget.
   typedef enum int {M_OFF, M_COUNT, M_QUEUE, M_RUN} mphase_e;
   mphase_e     m_ph [NP];
   int          m_left [NP], m_on_len [NP], m_per [NP], m_reps [NP];
   bit          m_cyclic [NP];
   bit [NP-1:0] m_pump, m_busy, m_done, m_sprev, m_fprev;
   int          edge_no;

   always @(posedge clk or posedge rst) begin : model
      int          slots;
      bit          se, fe, tk;
      bit [NP-1:0] g;
      if (rst) begin
         for (int c = 0; c < NP; c++) begin
            m_ph[c] = M_OFF; m_left[c] = 0; m_on_len[c] = 1; m_per[c] = 1;
            m_reps[c] = 0; m_cyclic[c] = 0;
         end
         m_pump = '0; m_busy = '0; m_done = '0; m_sprev = '0; m_fprev = '0;
         edge_no = 0;
      end else begin
         edge_no++;
         tk    = (edge_no % TD) == 0;
         slots = MA - $countones(m_pump);
         g     = '0;
         for (int c = 0; c < NP; c++) begin
            se = start[c] && !m_sprev[c];
            if (m_ph[c] == M_QUEUE && !stop[c] && !se && slots > 0) begin
               g[c] = 1'b1;
               slots--;
            end
         end
         for (int c = 0; c < NP; c++) begin
            se = start[c] && !m_sprev[c];
            fe = force_req[c] && !m_fprev[c];
            m_done[c] = 1'b0;
            if (stop[c]) begin
               m_ph[c] = M_OFF; m_cyclic[c] = 0;
            end else if (se) begin
               m_ph[c]     = M_COUNT;
               m_per[c]    = clamp1(int'(period_s[c*TW +: TW]));
               m_on_len[c] = clamp1(int'(on_s[c*TW +: TW]));
               m_left[c]   = m_per[c];
               m_reps[c]   = int'(repeat_n[c*RW +: RW]);
               m_cyclic[c] = 1;
            end else if (fe && m_ph[c] == M_OFF) begin
               m_ph[c]     = M_QUEUE;
               m_per[c]    = clamp1(int'(period_s[c*TW +: TW]));
               m_on_len[c] = clamp1(int'(on_s[c*TW +: TW]));
               m_cyclic[c] = 0;
            end else if (fe && m_ph[c] == M_COUNT) begin
               m_ph[c] = M_QUEUE;
            end else if (m_ph[c] == M_COUNT && tk) begin
               m_left[c]--;
               if (m_left[c] == 0) m_ph[c] = M_QUEUE;
            end else if (m_ph[c] == M_QUEUE && g[c]) begin
               m_ph[c]   = M_RUN;
               m_left[c] = m_on_len[c];
            end else if (m_ph[c] == M_RUN && tk) begin
               m_left[c]--;
               if (m_left[c] == 0) begin
                  if (!m_cyclic[c]) begin
                     m_ph[c] = M_OFF;
                  end else if (m_reps[c] == 1) begin
                     m_ph[c] = M_OFF; m_done[c] = 1'b1;
                  end else begin
                     if (m_reps[c] > 1) m_reps[c]--;
                     m_ph[c] = M_COUNT; m_left[c] = m_per[c];
                  end
               end
            end
            m_pump[c] = (m_ph[c] == M_RUN);
            m_busy[c] = (m_ph[c] != M_OFF);
         end
         m_sprev = start;
         m_fprev = force_req;
      end
   end

   // Observed-event bookkeeping used by the literal scenario checks.
   int          rise_cnt [NP], done_cnt [NP], rise_cyc [NP], fall_cyc [NP];
   int          width [NP], gap [NP];
   bit          done_on_fall [NP];
   int          max_act;
   bit [NP-1:0] prev_p;

   always @(posedge clk) begin : cmp
      #1;
      chk("pump_out", int'(pump_out), int'(m_pump));
      chk("busy", int'(busy), int'(m_busy));
      chk("done", int'(done), int'(m_done));
      chk("active_cnt", int'(active_cnt), $countones(m_pump));
      if (rst) begin
         prev_p = '0;
      end else begin
         for (int c = 0; c < NP; c++) begin
            if (pump_out[c] && !prev_p[c]) begin
               rise_cnt[c]++;
               gap[c]      = edge_no - fall_cyc[c];
               rise_cyc[c] = edge_no;
            end
            if (!pump_out[c] && prev_p[c]) begin
               fall_cyc[c] = edge_no;
               width[c]    = edge_no - rise_cyc[c];
            end
            if (done[c]) begin
               done_cnt[c]++;
               done_on_fall[c] = prev_p[c] && !pump_out[c];
            end
         end
         if (int'(active_cnt) > max_act) max_act = int'(active_cnt);
         prev_p = pump_out;
      end
   end

   task automatic clr_mon();
      for (int c = 0; c < NP; c++) begin
         rise_cnt[c] = 0; done_cnt[c] = 0; rise_cyc[c] = 0; fall_cyc[c] = 0;
         width[c] = 0; gap[c] = 0; done_on_fall[c] = 0;
      end
      max_act = 0;
   endtask

   task automatic set_cfg(input int c, input int per, input int on, input int rep);
      period_s[c*TW +: TW] = TW'(per);
      on_s[c*TW +: TW]     = TW'(on);
      repeat_n[c*RW +: RW] = RW'(rep);
   endtask

   task automatic pulse_start(input logic [NP-1:0] m);
      @(negedge clk); start = m;
      @(negedge clk); start = '0;
   endtask

   task automatic wait_idle(input int c, input int lim);
      int n = 0;
      while (busy[c] && n < lim) begin @(negedge clk); n++; end
      chk("timeout_idle", int'(busy[c]), 0);
   endtask

   task automatic wait_rises(input int c, input int cnt, input int lim);
      int n = 0;
      while (rise_cnt[c] < cnt && n < lim) begin @(negedge clk); n++; end
      chk("timeout_rise", rise_cnt[c], cnt);
   endtask

   initial begin
      #100000;
      $display("FAIL watchdog: simulation did not finish");
      $fatal(1, "watchdog expired");
   end

   initial begin
      rst = 1'b1; start = '0; stop = '0; force_req = '0;
      period_s = '0; on_s = '0; repeat_n = '0;
      clr_mon();
      repeat (3) @(negedge clk);
      rst = 1'b0;
      chk("rst_pump", int'(pump_out), 0);
      chk("rst_busy", int'(busy), 0);
      chk("rst_done", int'(done), 0);
      chk("rst_active", int'(active_cnt), 0);

      // A: two periodic pulses, 3 s on at 4 clk/s -> 11 cycles high, 9 low between.
      set_cfg(0, 2, 3, 2);
      clr_mon();
      pulse_start(4'b0001);
      chk("A_busy_after_start", int'(busy[0]), 1);
      wait_idle(0, 200);
      chk("A_rises", rise_cnt[0], 2);
      chk("A_width", width[0], 11);
      chk("A_gap", gap[0], 9);
      chk("A_done_cnt", done_cnt[0], 1);
      chk("A_done_on_fall", int'(done_on_fall[0]), 1);

      // B: three channels race for two slots; ch1 period 0 clamps to 1.
      set_cfg(0, 1, 2, 1);
      set_cfg(1, 0, 2, 1);
      set_cfg(2, 1, 2, 1);
      clr_mon();
      pulse_start(4'b0111);
      wait_idle(2, 200);
      chk("B_max_active", max_act, 2);
      chk("B_ch0_ch1_same_rise", rise_cyc[1] - rise_cyc[0], 0);
      chk("B_ch0_width", width[0], 7);
      chk("B_ch2_width", width[2], 7);
      chk("B_ch2_after_ch0", rise_cyc[2] - fall_cyc[0], 1);
      chk("B_ch2_done", done_cnt[2], 1);
      chk("B_ch1_done", done_cnt[1], 1);

      // C: one-shot force with on 0 (clamped to 1), aligned to give a 4-cycle pulse.
      set_cfg(2, 5, 0, 3);
      clr_mon();
      while ((edge_no % TD) != 2) @(negedge clk);
      force_req = 4'b0100;
      @(negedge clk); force_req = '0;
      wait_idle(2, 100);
      repeat (4) @(negedge clk);
      chk("C_rises", rise_cnt[2], 1);
      chk("C_width", width[2], 4);
      chk("C_no_done", done_cnt[2], 0);
      chk("C_idle", int'(busy[2]), 0);

      // D: infinite schedule stopped in the middle of its second pulse.
      set_cfg(0, 1, 3, 0);
      clr_mon();
      pulse_start(4'b0001);
      wait_rises(0, 2, 200);
      repeat (3) @(negedge clk);
      chk("D_on_before_stop", int'(pump_out[0]), 1);
      stop = 4'b0001;
      @(negedge clk);
      chk("D_pump_after_stop", int'(pump_out[0]), 0);
      chk("D_busy_after_stop", int'(busy[0]), 0);
      stop = '0;
      repeat (10) @(negedge clk);
      chk("D_no_done", done_cnt[0], 0);
      chk("D_stays_idle", int'(busy[0]), 0);

      // E: start+stop together stays idle; start+force together lands in WAIT.
      set_cfg(1, 2, 1, 1);
      @(negedge clk); start = 4'b0010; stop = 4'b0010;
      @(negedge clk); start = '0; stop = '0;
      chk("E_start_stop_idle", int'(busy[1]), 0);
      repeat (5) @(negedge clk);
      chk("E_still_idle", int'(busy[1]), 0);
      set_cfg(3, 3, 1, 1);
      @(negedge clk); start = 4'b1000; force_req = 4'b1000;
      @(negedge clk); start = '0; force_req = '0;
      chk("E_start_force_busy", int'(busy[3]), 1);
      repeat (2) @(negedge clk);
      chk("E_start_force_wait", int'(pump_out[3]), 0);
      @(negedge clk); stop = 4'b1000;
      @(negedge clk); stop = '0;

      // F: asynchronous reset mid-pulse, start held high through release.
      set_cfg(0, 1, 3, 0);
      clr_mon();
      @(negedge clk); start = 4'b0001;
      wait_rises(0, 1, 100);
      @(posedge clk); #3; rst = 1'b1;
      #1;
      chk("F_async_pump", int'(pump_out), 0);
      chk("F_async_busy", int'(busy), 0);
      chk("F_async_active", int'(active_cnt), 0);
      @(negedge clk); rst = 1'b0;
      clr_mon();
      @(negedge clk);
      chk("F_restart_busy", int'(busy[0]), 1);
      start = '0;
      wait_rises(0, 1, 100);
      @(negedge clk); stop = '1;
      @(negedge clk); stop = '0;
      chk("F_all_idle", int'(busy), 0);

      repeat (2) @(negedge clk);
      $display("*** SUMMARY: %0d compared / %0d mismatched ***", compared, mismatched);
      $finish;
   end

endmodule
